inst_line_buffer: RTL and testbench



---
 rtl/inst_line_buffer_if.sv | 24 ++
 rtl/inst_line_buffer.sv | 115 +++++++++++
 tb/tb_inst_line_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/inst_line_buffer_if.sv
// Fetch-side and arbiter-side signals of the instruction line buffer.
// The slave modport is the buffer itself; master is whatever drives it.
interface inst_line_buffer_if #(parameter int LINE_WORDS = 8);
    logic                      inst_read;
    logic [31:0]               inst_addr;
    logic                      inst_resp;
    logic [31:0]               inst_rdata;
    logic                      flush;
    logic                      pmem_read;
    logic [31:0]               pmem_address;
    logic [32*LINE_WORDS-1:0]  pmem_rdata;
    logic                      pmem_resp;
    logic [31:0]               hit_cnt;
    logic [31:0]               miss_cnt;

    modport slave (
        input  inst_read, inst_addr, flush, pmem_rdata, pmem_resp,
        output inst_resp, inst_rdata, pmem_read, pmem_address, hit_cnt, miss_cnt
    );
    modport master (
        output inst_read, inst_addr, flush, pmem_rdata, pmem_resp,
        input  inst_resp, inst_rdata, pmem_read, pmem_address, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/inst_line_buffer.sv
// Two-way fully-associative instruction line buffer with LRU replacement.
// Hits answer combinationally; misses issue one line read to the arbiter.
module inst_line_buffer #(
    parameter int LINE_WORDS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_line_buffer_if.slave    bus
);
    localparam int OFF = $clog2(LINE_WORDS);
    localparam int TW  = 30 - OFF;
    localparam int LW  = 32 * LINE_WORDS;

    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

    state_t          r_state;
    logic [1:0]      r_valid;
    logic [TW-1:0]   r_tag  [2];
    logic [LW-1:0]   r_line [2];
    logic            r_lru;
    logic            r_drop;
    logic            r_pmem_read;
    logic [31:0]     r_pmem_address;
    logic [31:0]     r_hit_cnt;
    logic [31:0]     r_miss_cnt;

    logic [TW-1:0]   w_tag;
    logic [OFF-1:0]  w_word;
    logic            w_hit0, w_hit1, w_hit, w_way;
    logic [LW-1:0]   w_line;
    logic            w_resp;
    logic            w_fill;
    logic            w_unused;

    assign w_tag    = bus.inst_addr[31:OFF+2];
    assign w_word   = bus.inst_addr[OFF+1:2];
    assign w_unused = ^bus.inst_addr[1:0];

    assign w_hit0 = r_valid[0] && (r_tag[0] == w_tag);
    assign w_hit1 = r_valid[1] && (r_tag[1] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;
    assign w_way  = w_hit1;
    assign w_line = r_line[w_way];

    assign w_resp = (r_state == IDLE) && bus.inst_read && w_hit && !bus.flush;
    // A returning line is kept only if no flush hit this miss, before or now.
    assign w_fill = (r_state == MISS) && bus.pmem_resp && !r_drop && !bus.flush;

    assign bus.inst_resp    = w_resp;
    assign bus.inst_rdata   = w_line[{w_word, 5'd0} +: 32];
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_address = r_pmem_address;
    assign bus.hit_cnt      = r_hit_cnt;
    assign bus.miss_cnt     = r_miss_cnt;

    // Tag and data storage carry no reset; valid bits gate them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[r_lru]  <= r_pmem_address[31:OFF+2];
            r_line[r_lru] <= bus.pmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_valid        <= 2'b00;
            r_lru          <= 1'b0;
            r_drop         <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_address <= '0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
        end else if (bus.flush) begin
            r_valid <= 2'b00;
            if (r_state == MISS) begin
                if (bus.pmem_resp) begin
                    r_pmem_read <= 1'b0;
                    r_drop      <= 1'b0;
                    r_state     <= IDLE;
                end else begin
                    r_drop <= 1'b1;
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.inst_read) begin
                        if (w_hit) begin
                            r_lru     <= ~w_way;
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                        end else begin
                            r_state        <= MISS;
                            r_pmem_read    <= 1'b1;
                            r_pmem_address <= {w_tag, {(OFF+2){1'b0}}};
                            r_miss_cnt     <= r_miss_cnt + 32'd1;
                        end
                    end
                end
                MISS: begin
                    if (bus.pmem_resp) begin
                        if (!r_drop) begin
                            r_valid[r_lru] <= 1'b1;
                            r_lru          <= ~r_lru;
                        end
                        r_pmem_read <= 1'b0;
                        r_drop      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_line_buffer.sv
// Randomized bench for inst_line_buffer against a line-address cache model.
// The bench also plays the arbiter, returning lines from a synthetic memory.
module tb_inst_line_buffer;
    localparam int WN = 8;
    localparam int LW = 32 * WN;
    localparam logic [31:0] LMASK = ~32'(WN * 4 - 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_line_buffer_if #(.LINE_WORDS(WN)) bus ();
    inst_line_buffer #(.LINE_WORDS(WN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LW-1:0] line_of(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < WN; i++) l[i*32 +: 32] = mem_word(base + 32'(i * 4));
        return l;
    endfunction

    // Model: each way remembers which line address it holds.
    bit          m_miss, m_drop, m_lru;
    bit  [1:0]   m_valid;
    logic [31:0] m_la [2];
    logic [31:0] m_addr, m_hits, m_misses;
    int          arb_cnt;
    int          lat_fix = -1;

    task automatic m_reset();
        m_miss = 0; m_drop = 0; m_lru = 0; m_valid = 2'b00;
        m_hits = 0; m_misses = 0; arb_cnt = 0;
    endtask

    task automatic step(input bit rd, input logic [31:0] a, input bit fl, output bit r);
        bit presp, hit, way;
        bus.inst_read = rd; bus.inst_addr = a; bus.flush = fl;
        presp = m_miss && (arb_cnt == 0);
        if (m_miss && arb_cnt > 0) arb_cnt--;
        bus.pmem_resp = presp;
        if (presp) bus.pmem_rdata = line_of(m_addr);
        else for (int i = 0; i < WN; i++) bus.pmem_rdata[i*32 +: 32] = $urandom();
        hit = 0; way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w] && m_la[w] == (a & LMASK)) begin hit = 1; way = w[0]; end
        r = !m_miss && rd && hit && !fl;
        #3;
        chk("inst_resp", 32'(bus.inst_resp), 32'(r));
        if (r) chk("inst_rdata", bus.inst_rdata, mem_word(a & ~32'h3));
        chk("pmem_read", 32'(bus.pmem_read), 32'(m_miss));
        if (m_miss) chk("pmem_address", bus.pmem_address, m_addr);
        chk("hit_cnt", bus.hit_cnt, m_hits);
        chk("miss_cnt", bus.miss_cnt, m_misses);
        if (fl) begin
            m_valid = 2'b00;
            if (m_miss) begin
                if (presp) begin m_miss = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else if (!m_miss) begin
            if (rd) begin
                if (hit) begin m_lru = !way; m_hits++; end
                else begin
                    m_miss = 1; m_addr = a & LMASK; m_misses++;
                    arb_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 5));
                end
            end
        end else if (presp) begin
            if (!m_drop) begin m_valid[m_lru] = 1; m_la[m_lru] = m_addr; m_lru = !m_lru; end
            m_miss = 0; m_drop = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] a, output int lat);
        bit r;
        lat = 0; r = 0;
        for (int i = 0; i < 40 && !r; i++) begin
            step(1, a, 0, r);
            if (!r) lat++;
        end
        chk("fetch_done", 32'(r), 32'd1);
    endtask

    task automatic do_areset();
        #2 rst_n = 0;
        #1;
        chk("arst_pmem_read", 32'(bus.pmem_read), 32'd0);
        chk("arst_inst_resp", 32'(bus.inst_resp), 32'd0);
        chk("arst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("arst_miss_cnt", bus.miss_cnt, 32'd0);
        m_reset();
        bus.pmem_resp = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        bit r;
        int lat;
        logic [31:0] a;
        rst_n = 0;
        bus.inst_read = 0; bus.inst_addr = 0; bus.flush = 0;
        bus.pmem_resp = 0; bus.pmem_rdata = '0;
        m_reset();
        #12;
        chk("rst_inst_resp", 32'(bus.inst_resp), 32'd0);
        chk("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
        chk("rst_pmem_address", bus.pmem_address, 32'd0);
        chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // Cold miss: resp three cycles after pmem_read, answer at cycle 5.
        lat_fix = 3;
        for (int c = 0; c < 6; c++) begin
            step(1, 32'h60, 0, r);
            if (c == 1) chk("cold_pmem_addr", bus.pmem_address, 32'h60);
            if (c == 5) chk("cold_resp_c5", 32'(r), 32'd1);
        end
        chk("cold_miss_cnt", bus.miss_cnt, 32'd1);
        step(1, 32'h64, 0, r); chk("hit_64", 32'(r), 32'd1);
        step(1, 32'h7C, 0, r); chk("hit_7c", 32'(r), 32'd1);
        step(1, 32'h7E, 0, r); chk("hit_7e", 32'(r), 32'd1);
        chk("hit_cnt_4", bus.hit_cnt, 32'd4);

        // LRU eviction.
        step(0, 32'h0, 1, r);
        lat_fix = 1;
        fetch(32'h000, lat); fetch(32'h100, lat);
        fetch(32'h000, lat); chk("lru_000_hit", 32'(lat), 32'd0);
        fetch(32'h200, lat); chk("lru_200_miss", 32'(lat > 0), 32'd1);
        fetch(32'h000, lat); chk("lru_000_kept", 32'(lat), 32'd0);
        fetch(32'h100, lat); chk("lru_100_evicted", 32'(lat > 0), 32'd1);

        // Address change mid-miss.
        lat_fix = 3;
        step(1, 32'h400, 0, r);
        step(1, 32'h500, 0, r);
        step(1, 32'h500, 0, r);
        chk("midmiss_addr", bus.pmem_address, 32'h400);
        fetch(32'h500, lat); chk("midmiss_second", 32'(lat > 0), 32'd1);

        // Flush while waiting, then flush coincident with resp.
        lat_fix = 4;
        step(1, 32'h600, 0, r);
        step(1, 32'h600, 0, r);
        step(1, 32'h600, 1, r);
        fetch(32'h600, lat); chk("flush_wait_remiss", 32'(lat > 5), 32'd1);
        fetch(32'h600, lat); chk("flush_refilled", 32'(lat), 32'd0);
        lat_fix = 2;
        step(1, 32'h700, 0, r);
        step(1, 32'h700, 0, r);
        step(1, 32'h700, 0, r);
        step(1, 32'h700, 1, r);
        fetch(32'h700, lat); chk("flush_coin_remiss", 32'(lat > 0), 32'd1);
        fetch(32'h600, lat); chk("flush_cleared", 32'(lat > 0), 32'd1);

        // Async reset mid-miss.
        lat_fix = 5;
        step(1, 32'h800, 0, r);
        step(1, 32'h800, 0, r);
        do_areset();
        fetch(32'h800, lat); chk("arst_remiss", 32'(lat > 0), 32'd1);

        // Random traffic over a small line pool.
        lat_fix = -1;
        for (int c = 0; c < 3000; c++) begin
            a = (32'($urandom_range(0, 5)) << 8) | 32'($urandom_range(0, 255)) & ~LMASK;
            if ($urandom_range(0, 499) == 0) do_areset();
            else step($urandom_range(0, 99) < 85, a, $urandom_range(0, 24) == 0, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
